// File: rtl/axis_dma_pkg.sv
// Shared types and helpers for the DMA-side AXI-Stream packet arbiter.
package axis_dma_pkg;

    // Arbiter FSM: IDLE picks a source, XFER forwards one packet from it.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Largest supported number of sources; sizes the round-robin helper.
    localparam int MAX_SRC = 8;

    // All byte lanes valid for a 32-bit beat.
    localparam logic [3:0] KEEP_ALL = 4'hF;

    // Round-robin pick: first set bit of req scanning upward from last+1,
    // wrapping modulo n. The scan runs backwards so the nearest request
    // after 'last' is the one that remains assigned. Returns 'last' if no
    // request is set.
    function automatic logic [2:0] next_rr(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
        logic [2:0] pick;
        int         idx;
        pick = last;
        for (int k = MAX_SRC; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow slot.
// Both out_valid_o and in_ready_o come straight from flops, so the stage
// breaks the combinational path in both directions while sustaining one
// beat per cycle when the downstream is always ready.
module axis_skid_buffer #(
    parameter int W = 37
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] out_data_q,   out_data_d;
    logic         out_valid_q,  out_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         skid_valid_q, skid_valid_d;

    // Accept whenever the overflow slot is empty.
    assign in_ready_o  = ~skid_valid_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

    // Refill the output register from the skid slot first, then from the input.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_valid_i && !skid_valid_q) begin
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
        end
    end

    // Storage registers, cleared asynchronously.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin merge of N_SRC AXI-Stream sources into one
// DMA S2MM stream. A grant holds until TLAST (or the MAX_BEATS limit, which
// forces TLAST and raises err_overlength), so DMA buffers never interleave.
// Optional per-source packet counters: define AXIS_ARB_STATS_EN.
//
// Handshake: a beat moves on any interface only in a cycle where its valid
// and ready are both high; valid never waits on ready, and payload is held
// stable by the sender while valid is high and ready is low.
module axis_pkt_rr_arbiter
    import axis_dma_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      enable,
    input  logic [N_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_SRC*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [N_SRC-1:0]          s_axis_tlast,
    input  logic [N_SRC-1:0]          s_axis_tvalid,
    output logic [N_SRC-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [DATA_W/8-1:0]       m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [$clog2(N_SRC)-1:0]  grant_idx,
    output logic                      busy,
    input  logic                      err_clear,
    output logic                      err_overlength
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [N_SRC*32-1:0]       pkt_count,
    input  logic                      stats_clear
`endif
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int GW     = $clog2(N_SRC);
    localparam int CW     = $clog2(MAX_BEATS + 1);
    localparam int PW     = KEEP_W + 1 + DATA_W;

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;

    logic [DATA_W-1:0] src_data;
    logic [KEEP_W-1:0] src_keep;
    logic              src_last;
    logic              src_valid;
    logic              force_last;
    logic              last_out;
    logic              beat_fire;
    logic              sb_in_valid;
    logic              sb_in_ready;
    logic [PW-1:0]     sb_out_data;

    // Select the granted source's payload and valid.
    always_comb begin
        src_data  = '0;
        src_keep  = '0;
        src_last  = 1'b0;
        src_valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == GW'(i)) begin
                src_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                src_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                src_last  = s_axis_tlast[i];
                src_valid = s_axis_tvalid[i];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, forward and count beats in XFER.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        err_d         = err_q;
        s_axis_tready = '0;
        sb_in_valid   = 1'b0;
        beat_fire     = 1'b0;
        force_last    = (beat_cnt_q == CW'(MAX_BEATS - 1));
        last_out      = src_last | force_last;
        if (err_clear) begin
            err_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable && (|s_axis_tvalid)) begin
                    grant_d    = GW'(next_rr(8'(s_axis_tvalid), 3'(grant_q), N_SRC));
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                s_axis_tready[grant_q] = sb_in_ready;
                sb_in_valid            = src_valid;
                beat_fire              = src_valid && sb_in_ready;
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    // A set in the same cycle as err_clear takes priority.
                    if (force_last && !src_last) begin
                        err_d = 1'b1;
                    end
                    if (last_out) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and bookkeeping registers; the reset grant makes source 0 win first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            grant_q    <= GW'(N_SRC - 1);
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    axis_skid_buffer #(
        .W (PW)
    ) u_out_skid (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_data_i   ({src_keep, last_out, src_data}),
        .in_valid_i  (sb_in_valid),
        .in_ready_o  (sb_in_ready),
        .out_data_o  (sb_out_data),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready)
    );

    assign m_axis_tkeep   = sb_out_data[PW-1 -: KEEP_W];
    assign m_axis_tlast   = sb_out_data[DATA_W];
    assign m_axis_tdata   = sb_out_data[DATA_W-1:0];
    assign grant_idx      = grant_q;
    assign busy           = (state_q == ST_XFER);
    assign err_overlength = err_q;

`ifdef AXIS_ARB_STATS_EN
    logic [31:0] cnt_q [N_SRC];

    // Count packet ends (including forced ones) as they enter the output stage.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (stats_clear) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (beat_fire && last_out) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_cnt_out
        assign pkt_count[g*32 +: 32] = cnt_q[g];
    end
`endif

endmodule
